// File: rtl/act_loader_if.sv
// Bundles the activation-loader control inputs, RAM read port and output stream.
// master = loader side, slave = environment (controller, RAM, array input stage).
interface act_loader_if;
    logic         i_start;
    logic [1:0]   i_mode;
    logic [287:0] i_vsq_sf;
    logic [17:0]  i_int4_sf;
    logic [17:0]  i_int8_sf;
    logic         o_ram_re;
    logic [5:0]   o_ram_addr;
    logic [63:0]  i_ram_data;
    logic [255:0] o_data;
    logic         o_valid;
    logic         i_ready;
    logic         o_busy;
    logic         o_done;

    modport master (
        input  i_start, i_mode, i_vsq_sf, i_int4_sf, i_int8_sf, i_ram_data, i_ready,
        output o_ram_re, o_ram_addr, o_data, o_valid, o_busy, o_done
    );

    modport slave (
        output i_start, i_mode, i_vsq_sf, i_int4_sf, i_int8_sf, i_ram_data, i_ready,
        input  o_ram_re, o_ram_addr, o_data, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/act_loader.sv
// Reads packed INT4/INT8 activation rows from the 64-word RAM, dequantizes them with the
// latched scale factors and streams 16-lane INT16 rows. Build option: ACT_LOADER_RND_EN.
module act_loader (
    input  logic         i_clk,
    input  logic         i_rst,
    act_loader_if.master bus
);
    // state   | meaning
    // S_IDLE  | waiting for i_start
    // S_READ  | issuing RAM reads as FIFO credit allows
    // S_DRAIN | last read issued, waiting for pipeline and FIFO to empty
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_DRAIN = 2'd2} state_t;

    localparam logic [1:0] M_VSQ  = 2'd0;
    localparam logic [1:0] M_INT4 = 2'd1;
    localparam logic [1:0] M_INT8 = 2'd2;

`ifdef ACT_LOADER_RND_EN
    localparam logic [27:0] RND_BIAS = 28'd512;
`else
    localparam logic [27:0] RND_BIAS = 28'd0;
`endif

    state_t       state_q, state_d;
    logic [1:0]   mode_q, mode_d;
    logic [287:0] vsq_sf_q, vsq_sf_d;
    logic [17:0]  int4_sf_q, int4_sf_d;
    logic [17:0]  int8_sf_q, int8_sf_d;
    logic [5:0]   addr_q, addr_d;
    logic [5:0]   row_q, row_d;
    logic         hi_next_q, hi_next_d;
    logic         rv_q, rv_d;
    logic         rhi_q, rhi_d;
    logic [63:0]  lo_q, lo_d;
    logic [1:0]   inflight_q, inflight_d;
    logic [255:0] mem_q [2];
    logic [255:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;

    logic         start_acc;
    logic         is_int8;
    logic         valid;
    logic         fifo_rd;
    logic         fifo_wr;
    logic         lo_cap;
    logic [1:0]   occ_eff;
    logic [2:0]   credit_sum;
    logic         rd_issue;
    logic         row_issue;
    logic         busy;
    logic         done;
    logic [17:0]  sf_sel;
    logic [255:0] row_deq;

    // q sign-extended to 8 bits, times unsigned UQ8.10 scale, shifted back to integer and saturated
    function automatic logic [15:0] dequant(input logic [7:0] q, input logic [17:0] sf);
        logic signed [26:0] qx;
        logic signed [26:0] sx;
        logic signed [26:0] p;
        logic signed [27:0] pr;
        logic signed [17:0] sh;
        logic [15:0]        res;
        qx = 27'($signed(q));
        sx = 27'($signed({1'b0, sf}));
        p  = qx * sx;
        pr = $signed({p[26], p}) + $signed(RND_BIAS);
        sh = 18'(pr >>> 10);
        if (!sh[17] && (sh[16] || sh[15])) begin
            res = 16'h7FFF;
        end else if (sh[17] && !(sh[16] && sh[15])) begin
            res = 16'h8000;
        end else begin
            res = sh[15:0];
        end
        return res;
    endfunction

    assign start_acc = (state_q == S_IDLE) && bus.i_start;
    assign is_int8   = (mode_q == M_INT8);
    assign valid     = (cnt_q != 2'd0);
    assign fifo_rd   = valid && bus.i_ready;
    assign fifo_wr   = rv_q && (!is_int8 || rhi_q);
    assign lo_cap    = rv_q && is_int8 && !rhi_q;

    // Credit counts this cycle's pop so a full-rate stream keeps one read issued per cycle
    assign occ_eff    = cnt_q - {1'b0, fifo_rd};
    assign credit_sum = {1'b0, occ_eff} + {1'b0, inflight_q};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.i_start) state_d = S_READ;
            S_READ:  if (rd_issue && (addr_q == 6'd63)) state_d = S_DRAIN;
            S_DRAIN: if ((cnt_q == 2'd0) && (inflight_q == 2'd0)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_issue  = 1'b0;
        row_issue = 1'b0;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        case (state_q)
            S_READ: begin
                // High half of an INT8 row already holds its credit from the low read
                if (is_int8 && hi_next_q) begin
                    rd_issue = 1'b1;
                end else if (credit_sum < 3'd2) begin
                    rd_issue  = 1'b1;
                    row_issue = 1'b1;
                end
            end
            S_DRAIN: done = (cnt_q == 2'd0) && (inflight_q == 2'd0);
            default: ;
        endcase
    end

    always_comb begin
        logic [3:0] nib;
        logic [7:0] q8;
        nib     = '0;
        q8      = '0;
        row_deq = '0;
        case (mode_q)
            M_VSQ:   sf_sel = vsq_sf_q[18*row_q[5:2] +: 18];
            M_INT8:  sf_sel = int8_sf_q;
            default: sf_sel = int4_sf_q;
        endcase
        for (int k = 0; k < 16; k++) begin
            nib = bus.i_ram_data[4*k +: 4];
            q8  = is_int8 ? {nib, lo_q[4*k +: 4]} : {{4{nib[3]}}, nib};
            row_deq[16*k +: 16] = dequant(q8, sf_sel);
        end
    end

    always_comb begin
        mode_d     = mode_q;
        vsq_sf_d   = vsq_sf_q;
        int4_sf_d  = int4_sf_q;
        int8_sf_d  = int8_sf_q;
        addr_d     = addr_q;
        row_d      = row_q;
        hi_next_d  = hi_next_q;
        lo_d       = lo_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rv_d       = rd_issue;
        rhi_d      = rd_issue && is_int8 && hi_next_q;
        if (start_acc) begin
            mode_d    = (bus.i_mode == 2'd3) ? M_INT4 : bus.i_mode;
            vsq_sf_d  = bus.i_vsq_sf;
            int4_sf_d = bus.i_int4_sf;
            int8_sf_d = bus.i_int8_sf;
            addr_d    = '0;
            row_d     = '0;
            hi_next_d = 1'b0;
        end
        if (rd_issue) begin
            addr_d = addr_q + 6'd1;
            if (is_int8) hi_next_d = !hi_next_q;
        end
        if (lo_cap) lo_d = bus.i_ram_data;
        if (fifo_wr) begin
            mem_d[wr_ptr_q] = row_deq;
            wr_ptr_d        = !wr_ptr_q;
            row_d           = row_q + 6'd1;
        end
        if (fifo_rd) rd_ptr_d = !rd_ptr_q;
        cnt_d      = cnt_q + {1'b0, fifo_wr} - {1'b0, fifo_rd};
        inflight_d = inflight_q + {1'b0, row_issue} - {1'b0, fifo_wr};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q     <= M_VSQ;
            vsq_sf_q   <= '0;
            int4_sf_q  <= '0;
            int8_sf_q  <= '0;
            addr_q     <= '0;
            row_q      <= '0;
            hi_next_q  <= 1'b0;
            rv_q       <= 1'b0;
            rhi_q      <= 1'b0;
            lo_q       <= '0;
            inflight_q <= '0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            mode_q     <= mode_d;
            vsq_sf_q   <= vsq_sf_d;
            int4_sf_q  <= int4_sf_d;
            int8_sf_q  <= int8_sf_d;
            addr_q     <= addr_d;
            row_q      <= row_d;
            hi_next_q  <= hi_next_d;
            rv_q       <= rv_d;
            rhi_q      <= rhi_d;
            lo_q       <= lo_d;
            inflight_q <= inflight_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.o_ram_re   = rd_issue;
    assign bus.o_ram_addr = addr_q;
    assign bus.o_data     = mem_q[rd_ptr_q];
    assign bus.o_valid    = valid;
    assign bus.o_busy     = busy;
    assign bus.o_done     = done;
endmodule
